// File: rtl/vreg_issue_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vrvv_pkg : vlmul encodings, issue FSM states, queue entry type        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package vrvv_pkg;

  localparam logic [2:0] LMUL1     = 3'b000;
  localparam logic [2:0] LMUL2     = 3'b001;
  localparam logic [2:0] LMUL4     = 3'b010;
  localparam logic [2:0] LMUL8     = 3'b011;
  localparam logic [2:0] LMUL_RSVD = 3'b100;
  localparam logic [2:0] LMUL_F8   = 3'b101;
  localparam logic [2:0] LMUL_F4   = 3'b110;
  localparam logic [2:0] LMUL_F2   = 3'b111;

  localparam int VREG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [VREG_ADDR_W-1:0] addr;
    logic [2:0]             vlmul;
  } entry_t;

  // Only the low three address bits matter: the largest group is LMUL8.
  function automatic logic vlmul_legal(input logic [2:0] addr_lo, input logic [2:0] vlmul);
    logic ok;
    ok = 1'b1;
    case (vlmul)
      LMUL1:     ok = 1'b1;
      LMUL2:     ok = ~addr_lo[0];
      LMUL4:     ok = (addr_lo[1:0] == 2'b00);
      LMUL8:     ok = (addr_lo == 3'b000);
      LMUL_RSVD: ok = 1'b0;
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vreg_issue_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vreg_issue_queue_if : decode request, AGU dispatch and status bundle  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface vreg_issue_queue_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_vlmul;
  logic                  flush;
  logic                  agu_idle;
  logic                  agu_en;
  logic [ADDR_WIDTH-1:0] agu_addr;
  logic [2:0]            agu_vlmul;
  logic                  illegal_valid;
  logic [ADDR_WIDTH-1:0] illegal_addr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  busy;

  modport master (
    output req_valid, req_addr, req_vlmul, flush, agu_idle,
    input  req_ready, agu_en, agu_addr, agu_vlmul, illegal_valid, illegal_addr, count, busy
  );

  modport slave (
    input  req_valid, req_addr, req_vlmul, flush, agu_idle,
    output req_ready, agu_en, agu_addr, agu_vlmul, illegal_valid, illegal_addr, count, busy
  );
endinterface
`default_nettype wire

// File: rtl/vreg_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vreg_fifo : synchronous FIFO with push/pop/flush and occupancy count  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vreg_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt == CNT_WIDTH'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/vreg_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vreg_issue_queue : legality-checked vreg group queue feeding the AGU  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vreg_issue_queue
  import vrvv_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst_n,
  vreg_issue_queue_if.slave bus
);
  localparam int ENTRY_W = ADDR_WIDTH + 3;

  issue_state_e          state;
  logic                  full;
  logic                  empty;
  logic                  consume;
  logic                  legal;
  logic                  push;
  logic                  dispatch;
  logic                  reject;
  logic [ENTRY_W-1:0]    wdata;
  logic [ENTRY_W-1:0]    rdata;
  logic [CNT_WIDTH-1:0]  count;
  logic                  agu_en;
  logic [ADDR_WIDTH-1:0] agu_addr;
  logic [2:0]            agu_vlmul;
  logic                  illegal_valid;
  logic [ADDR_WIDTH-1:0] illegal_addr;

  assign consume  = bus.req_valid & ~full;
  assign legal    = vlmul_legal(bus.req_addr[2:0], bus.req_vlmul);
  assign push     = consume & legal & ~bus.flush;
  assign reject   = consume & ~legal & ~bus.flush;
  assign wdata    = {bus.req_addr, bus.req_vlmul};
  // agu_idle reaches only the pop and next-state logic; agu_en stays a flop.
  assign dispatch = (state != ISSUE) & ~bus.flush & bus.agu_idle & ~empty;

  vreg_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (dispatch),
    .flush (bus.flush),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      agu_en        <= 1'b0;
      agu_addr      <= '0;
      agu_vlmul     <= '0;
      illegal_valid <= 1'b0;
      illegal_addr  <= '0;
    end else begin
      agu_en        <= dispatch;
      illegal_valid <= reject;
      if (reject)   illegal_addr <= bus.req_addr;
      if (dispatch) {agu_addr, agu_vlmul} <= rdata;
      case (state)
        IDLE:    if (dispatch) state <= ISSUE;
        ISSUE:   state <= WAIT;
        WAIT: begin
          if (dispatch)                               state <= ISSUE;
          else if (~bus.flush & bus.agu_idle & empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ~full;
  assign bus.agu_en        = agu_en;
  assign bus.agu_addr      = agu_addr;
  assign bus.agu_vlmul     = agu_vlmul;
  assign bus.illegal_valid = illegal_valid;
  assign bus.illegal_addr  = illegal_addr;
  assign bus.count         = count;
  assign bus.busy          = (count != '0) | (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_vreg_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vreg_issue_queue : directed vectors and sequences for the queue    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_vreg_issue_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_q[$];

  vreg_issue_queue_if #(.ADDR_WIDTH(5), .CNT_WIDTH(3)) bus ();

  vreg_issue_queue #(.ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [2:0] vlmul;
    logic       legal;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int addr, input int vlmul);
    bus.req_valid = 1'b1;
    bus.req_addr  = 5'(addr);
    bus.req_vlmul = 3'(vlmul);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // AGU model: goes busy for two cycles after every strobe.
  task automatic drain(input int n, input int max_cyc);
    int   got = 0;
    int   hold = 0;
    logic prev_en = 1'b0;
    logic took;
    for (int c = 0; c < max_cyc && got < n; c++) begin
      took = bus.req_valid & bus.req_ready;
      tick();
      if (took) bus.req_valid = 1'b0;
      if (bus.agu_en) begin
        chk("agu_en_width", int'(prev_en), 0);
        chk("dispatch_addr", int'(bus.agu_addr), exp_q[got]);
        got++;
        hold = 2;
      end else if (hold > 0) begin
        hold--;
      end
      prev_en      = bus.agu_en;
      bus.agu_idle = (hold == 0);
    end
    chk("dispatch_count", got, n);
    bus.agu_idle = 1'b1;
    for (int c = 0; c < 4; c++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_seen;

    vecs[0]  = '{5'd8,  3'b010, 1'b1};
    vecs[1]  = '{5'd6,  3'b010, 1'b0};
    vecs[2]  = '{5'd4,  3'b100, 1'b0};
    vecs[3]  = '{5'd3,  3'b000, 1'b1};
    vecs[4]  = '{5'd3,  3'b001, 1'b0};
    vecs[5]  = '{5'd2,  3'b001, 1'b1};
    vecs[6]  = '{5'd12, 3'b011, 1'b0};
    vecs[7]  = '{5'd16, 3'b011, 1'b1};
    vecs[8]  = '{5'd7,  3'b101, 1'b1};
    vecs[9]  = '{5'd31, 3'b111, 1'b1};
    vecs[10] = '{5'd30, 3'b110, 1'b1};

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_vlmul = '0;
    bus.flush     = 1'b0;
    bus.agu_idle  = 1'b1;
    tick();
    tick();
    chk("rst_count", int'(bus.count), 0);
    chk("rst_ready", int'(bus.req_ready), 1);
    chk("rst_agu_en", int'(bus.agu_en), 0);
    chk("rst_agu_addr", int'(bus.agu_addr), 0);
    chk("rst_illegal_valid", int'(bus.illegal_valid), 0);
    chk("rst_illegal_addr", int'(bus.illegal_addr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    tick();

    // Single dispatch: strobe lands in the cycle after the edge following the consume.
    push_one(8, 3'b010);
    chk("single_count_after_push", int'(bus.count), 1);
    chk("single_no_early_en", int'(bus.agu_en), 0);
    tick();
    chk("single_en", int'(bus.agu_en), 1);
    chk("single_addr", int'(bus.agu_addr), 8);
    chk("single_vlmul", int'(bus.agu_vlmul), 2);
    chk("single_count_pop", int'(bus.count), 0);
    tick();
    chk("single_en_one_cycle", int'(bus.agu_en), 0);
    chk("single_busy_wait", int'(bus.busy), 1);
    tick();
    chk("single_busy_idle", int'(bus.busy), 0);
    chk("single_addr_hold", int'(bus.agu_addr), 8);

    // Legality table with the AGU held busy so nothing dispatches.
    bus.agu_idle = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push_one(int'(vecs[i].addr), int'(vecs[i].vlmul));
      chk("tbl_illegal_valid", int'(bus.illegal_valid), int'(!vecs[i].legal));
      chk("tbl_count", int'(bus.count), int'(vecs[i].legal));
      if (!vecs[i].legal) chk("tbl_illegal_addr", int'(bus.illegal_addr), int'(vecs[i].addr));
      chk("tbl_no_en", int'(bus.agu_en), 0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("tbl_pulse_one_cycle", int'(bus.illegal_valid), 0);
      chk("tbl_flush_count", int'(bus.count), 0);
    end

    // Fill and backpressure.
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 5'(i);
      bus.req_vlmul = 3'b000;
      chk("fill_ready", int'(bus.req_ready), 1);
      tick();
    end
    bus.req_addr = 5'd4;
    chk("full_ready", int'(bus.req_ready), 0);
    chk("full_count", int'(bus.count), 4);
    tick();
    chk("full_hold_count", int'(bus.count), 4);
    bus.agu_idle = 1'b1;
    exp_q = '{0, 1, 2, 3, 4};
    drain(5, 60);
    chk("fill_end_count", int'(bus.count), 0);
    chk("fill_end_busy", int'(bus.busy), 0);

    // Concurrent push and pop with three entries queued.
    bus.agu_idle = 1'b0;
    push_one(10, 3'b001);
    push_one(12, 3'b001);
    push_one(14, 3'b001);
    chk("conc_pre_count", int'(bus.count), 3);
    bus.agu_idle  = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 5'd16;
    bus.req_vlmul = 3'b001;
    tick();
    bus.req_valid = 1'b0;
    chk("conc_count", int'(bus.count), 3);
    chk("conc_en", int'(bus.agu_en), 1);
    chk("conc_addr", int'(bus.agu_addr), 10);
    exp_q = '{12, 14, 16};
    drain(3, 40);
    chk("conc_end_count", int'(bus.count), 0);

    // Flush during an in-flight dispatch, with a same-cycle push.
    bus.agu_idle = 1'b0;
    push_one(20, 3'b001);
    push_one(22, 3'b001);
    push_one(24, 3'b001);
    push_one(26, 3'b001);
    bus.agu_idle = 1'b1;
    tick();
    chk("flush_en_inflight", int'(bus.agu_en), 1);
    chk("flush_pre_count", int'(bus.count), 3);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 5'd28;
    bus.req_vlmul = 3'b001;
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_count", int'(bus.count), 0);
    chk("flush_en_done", int'(bus.agu_en), 0);
    chk("flush_no_illegal", int'(bus.illegal_valid), 0);
    en_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.agu_en) en_seen++;
    end
    chk("flush_no_dispatch", en_seen, 0);
    chk("flush_busy", int'(bus.busy), 0);

    // Reset while in WAIT with two entries left.
    bus.agu_idle = 1'b0;
    push_one(2, 3'b001);
    push_one(4, 3'b001);
    push_one(6, 3'b001);
    bus.agu_idle = 1'b1;
    tick();
    chk("rstm_en", int'(bus.agu_en), 1);
    bus.agu_idle = 1'b0;
    tick();
    chk("rstm_wait_count", int'(bus.count), 2);
    rst_n = 1'b0;
    tick();
    chk("rstm_count", int'(bus.count), 0);
    chk("rstm_en_low", int'(bus.agu_en), 0);
    chk("rstm_busy", int'(bus.busy), 0);
    chk("rstm_agu_addr", int'(bus.agu_addr), 0);
    rst_n = 1'b1;
    bus.agu_idle = 1'b1;
    en_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.agu_en) en_seen++;
    end
    chk("rstm_no_dispatch", en_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vreg_issue_queue.md
Name: vreg_issue_queue

Overview:
- Buffers decoded vector register-group requests (base address + vlmul) ahead of the address generator unit (AGU).
- Checks group legality at enqueue and dispatches one request at a time to the AGU's en/addr_in/vlmul inputs, gated by AGU idle.
- Sits directly upstream of the AGU, between instruction decode and the vector register-file address path.

Parameters:
- ADDR_WIDTH, 5, vector register address width (32 registers).
- DEPTH, 4, queue entries; power of two, >= 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  decode offers a request.
- req_ready  out  1  queue accepts a request this cycle.
- req_addr  in  ADDR_WIDTH  register-group base address.
- req_vlmul  in  3  LMUL encoding (RVV vlmul).
- flush  in  1  drop all queued, undispatched entries.
- agu_idle  in  1  AGU idle indication.
- agu_en  out  1  one-cycle dispatch strobe to the AGU.
- agu_addr  out  ADDR_WIDTH  base address to the AGU.
- agu_vlmul  out  3  vlmul to the AGU.
- illegal_valid  out  1  one-cycle pulse: a rejected request.
- illegal_addr  out  ADDR_WIDTH  base address of the rejected request.
- count  out  CNT_WIDTH  current occupancy.
- busy  out  1  count != 0 or FSM != IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Pointers, count, agu_en, illegal_valid and FSM are cleared; FSM goes to IDLE.
  - agu_addr, agu_vlmul and illegal_addr reset to 0.
  - Reset mid-dispatch discards all entries; no further agu_en is issued.
- req_ready = ~full, combinational from count; there is no pass-through when full.
- Handshake:
  - A request is consumed when req_valid & req_ready.
  - Inputs are held by the source until consumed.
- Legality check at consume:
  - vlmul 000..011: legal iff the low vlmul bits of req_addr are 0 (aligned to 2^vlmul).
  - vlmul 100: reserved, always illegal.
  - vlmul 101..111: fractional, always legal.
- Legal request: written at the tail; count increments.
- Illegal request:
  - Not written to the queue.
  - illegal_valid=1 on the next cycle only, with illegal_addr = req_addr.
  - Illegal requests are consumed only when req_ready=1.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when count>0 & agu_idle.
  - ISSUE: agu_en=1; agu_addr/agu_vlmul hold the head entry, registered on entry to ISSUE; head pops on the same edge. ISSUE -> WAIT unconditionally.
  - WAIT -> ISSUE when agu_idle & count>0.
  - WAIT -> IDLE when agu_idle & count==0.
  - Otherwise WAIT holds.
- agu_en is a register output, asserted only in ISSUE and always exactly one cycle wide. The AGU's idle depends combinationally on en, so no combinational path from agu_idle to agu_en is allowed.
- Latency: a legal request consumed at edge t into an empty queue, with the AGU idle, gives agu_en=1 in the cycle after edge t+1.
- Simultaneous push and pop: both take effect; count is unchanged.
- Full condition: a push while full cannot occur because req_ready=0.
- flush:
  - Sets count=0 and head=tail on the next edge.
  - Has priority over a same-cycle push; the pushed entry is dropped and no illegal pulse is generated.
  - An agu_en already asserted is not retracted. FSM goes to WAIT if currently ISSUE, else keeps its state.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- agu_addr and agu_vlmul hold their last dispatched values between dispatches.

Decomposition:
- Package vrvv_pkg holds:
  - the vlmul encodings (LMUL1=3'b000 .. LMUL8=3'b011, LMUL_RSVD=3'b100, fractional 3'b101..3'b111);
  - the issue FSM state enum (IDLE, ISSUE, WAIT);
  - an entry struct {addr, vlmul}.
- One natural sub-module, vreg_fifo: a generic synchronous FIFO with push/pop/flush, full/empty and count. The legality check and FSM stay in the top.

Test Plan:
- Reset and single dispatch: reset, then push addr=8 vlmul=010 with agu_idle=1 -> agu_en=1 for exactly one cycle, one cycle after the consuming edge, with agu_addr=8 and agu_vlmul=010; count returns to 0.
- Misaligned and reserved rejection:
  - push addr=6 vlmul=010 -> illegal_valid pulse with illegal_addr=6, count unchanged, no agu_en;
  - push addr=4 vlmul=100 -> illegal_valid pulse with illegal_addr=4.
- Fill and backpressure: hold agu_idle=0 and push 5 legal requests (0, 1, 2, 3, 4, vlmul=000) -> req_ready=0 after 4 pushes and count=4. Release agu_idle -> dispatches 0, 1, 2, 3 in order, each separated by WAIT until agu_idle returns, then request 4 is accepted.
- Concurrent push/pop at DEPTH-1: with count=3, push while ISSUE pops -> count stays 3 and FIFO order is preserved.
- Flush: queue holding 3 entries, assert flush together with a push -> count=0, the pushed entry is dropped, the in-flight agu_en completes, and there are no further dispatches.
- Reset mid-operation: deassert rst_n while in WAIT with count=2 -> next cycle count=0, agu_en=0, FSM=IDLE, busy=0.
